// File: rtl/serial_twos_complement.sv
// Bit-serial two's-complement pass / negate / absolute-value unit.
// One operand bit per cycle, LSB first, with a parallel copy assembled in dout.
module serial_twos_complement #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             seen;
    logic             bit_in;
    logic             obit;

    function automatic logic neg_sel(input logic [1:0] m, input logic msb);
        logic n;
        n = 1'b0;
        unique case (1'b1)
            (m == 2'b01): n = 1'b1;
            (m == 2'b10): n = msb;
            default:      n = 1'b0;
        endcase
        return n;
    endfunction

    // Negation: copy bits up to and including the first 1, invert the rest.
    assign bit_in = opnd[0];
    assign obit   = (neg & seen) ? ~bit_in : bit_in;
    assign ready  = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            opnd       <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            seen       <= 1'b0;
            dout       <= '0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end else begin
            valid      <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opnd  <= din;
                        neg   <= neg_sel(mode, din[WIDTH-1]);
                        cnt   <= '0;
                        seen  <= 1'b0;
                        dout  <= '0;
                        ovf   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sout       <= obit;
                    sout_valid <= 1'b1;
                    dout       <= {obit, dout[WIDTH-1:1]};
                    opnd       <= opnd >> 1;
                    seen       <= seen | bit_in;
                    cnt        <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // MSB set with no lower 1 seen: the most negative value.
                        ovf   <= neg & bit_in & ~seen;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_twos_complement.sv
// Bench for serial_twos_complement: three widths (4/16/32) driven in parallel,
// checked against an arithmetic reference model plus fixed 16-bit vectors.
module tb_serial_twos_complement;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st = '0;
    logic [1:0]  mode = '0;
    logic [63:0] din = '0;

    logic [2:0]  rd, so, sv, vl, ov;
    logic [3:0]  d4;
    logic [15:0] d16;
    logic [31:0] d32;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_twos_complement #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .mode(mode), .din(din[3:0]),
        .ready(rd[0]), .sout(so[0]), .sout_valid(sv[0]), .dout(d4),
        .valid(vl[0]), .ovf(ov[0])
    );

    serial_twos_complement #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .mode(mode), .din(din[15:0]),
        .ready(rd[1]), .sout(so[1]), .sout_valid(sv[1]), .dout(d16),
        .valid(vl[1]), .ovf(ov[1])
    );

    serial_twos_complement #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .mode(mode), .din(din[31:0]),
        .ready(rd[2]), .sout(so[2]), .sout_valid(sv[2]), .dout(d32),
        .valid(vl[2]), .ovf(ov[2])
    );

    function automatic int wof(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] dq(input int i);
        case (i)
            0:       return 64'(d4);
            1:       return 64'(d16);
            default: return 64'(d32);
        endcase
    endfunction

    // Reference: negate is plain arithmetic negation modulo 2^w.
    function automatic logic [63:0] ref_res(input int w, input logic [1:0] m,
                                            input logic [63:0] d, output logic o);
        logic [63:0] mask, x, r;
        logic        n;
        mask = (64'd1 << w) - 64'd1;
        x    = d & mask;
        n    = (m == 2'b01) || (m == 2'b10 && x[w-1]);
        r    = n ? ((64'd0 - x) & mask) : x;
        o    = n && (x == (64'd1 << (w - 1)));
        return r;
    endfunction

    task automatic chk(input string nm, input int w, input logic [63:0] a,
                       input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s W=%0d got %h want %h", nm, w, a, e);
        end
    endtask

    task automatic do_op(input logic [1:0] m, input logic [63:0] d,
                         input bit scr, input bit has16,
                         input logic [15:0] e16, input logic e16o);
        logic [63:0] stream [3];
        logic [63:0] vd [3];
        logic        vo [3];
        int          nb [3], fk [3], vc [3], vk [3];
        logic [63:0] e;
        logic        eo;
        for (int i = 0; i < 3; i++) begin
            stream[i] = '0; vd[i] = '0; vo[i] = 1'b0;
            nb[i] = 0; fk[i] = 0; vc[i] = 0; vk[i] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("ready_pre", wof(i), 64'(rd[i]), 64'd1);
        st   = 3'b111;
        mode = m;
        din  = d;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sv[i]) begin
                    if (nb[i] == 0) fk[i] = k;
                    stream[i] = stream[i] | (64'(so[i]) << nb[i]);
                    nb[i]++;
                end
                if (vl[i]) begin
                    vc[i]++;
                    vk[i] = k;
                    vd[i] = dq(i);
                    vo[i] = ov[i];
                end
            end
            st = '0;
            if (scr) begin
                din  = {$urandom, $urandom};
                mode = 2'($urandom_range(0, 3));
                for (int i = 0; i < 3; i++)
                    st[i] = (k <= wof(i)) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            e = ref_res(wof(i), m, d, eo);
            chk("nbits", wof(i), 64'(nb[i]), 64'(wof(i)));
            chk("stream", wof(i), stream[i], e);
            chk("first_bit_cyc", wof(i), 64'(fk[i]), 64'd2);
            chk("valid_count", wof(i), 64'(vc[i]), 64'd1);
            chk("valid_cyc", wof(i), 64'(vk[i]), 64'(wof(i) + 1));
            chk("dout", wof(i), vd[i], e);
            chk("ovf", wof(i), 64'(vo[i]), 64'(eo));
            chk("dout_hold", wof(i), dq(i), e);
            chk("ready_post", wof(i), 64'(rd[i]), 64'd1);
        end
        if (has16) begin
            chk("tbl_dout", 16, vd[1], 64'(e16));
            chk("tbl_ovf", 16, 64'(vo[1]), 64'(e16o));
        end
        mode = '0;
        din  = '0;
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [15:0] e;
        logic        o;
        bit          scr;
    } vec_t;

    vec_t tbl [9];
    int   nv;

    initial begin
        tbl[0] = '{2'b01, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 16'h8000, 16'h8000, 1'b1, 1'b0};
        tbl[2] = '{2'b01, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{2'b10, 16'hFFFB, 16'h0005, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 16'h0005, 16'h0005, 1'b0, 1'b0};
        tbl[5] = '{2'b11, 16'h1234, 16'h1234, 1'b0, 1'b0};
        tbl[6] = '{2'b00, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1};
        tbl[7] = '{2'b01, 16'h7FFF, 16'h8001, 1'b0, 1'b1};
        tbl[8] = '{2'b10, 16'h8000, 16'h8000, 1'b1, 1'b1};

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", wof(i), 64'(rd[i]), 64'd1);
            chk("rst_dout", wof(i), dq(i), 64'd0);
            chk("rst_ovf", wof(i), 64'(ov[i]), 64'd0);
            chk("rst_valid", wof(i), 64'(vl[i]), 64'd0);
            chk("rst_sout_valid", wof(i), 64'(sv[i]), 64'd0);
            chk("rst_sout", wof(i), 64'(so[i]), 64'd0);
        end
        rst_n = 1'b1;

        for (int t = 0; t < 9; t++)
            do_op(tbl[t].m, {48'h0, tbl[t].d}, tbl[t].scr, 1'b1, tbl[t].e, tbl[t].o);

        // Reset in the middle of SHIFT: operation abandoned.
        @(negedge clk);
        st = 3'b111; mode = 2'b01; din = 64'h0000_1234_5678_1234;
        @(negedge clk);
        st = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_ready", wof(i), 64'(rd[i]), 64'd1);
            chk("midrst_dout", wof(i), dq(i), 64'd0);
            chk("midrst_ovf", wof(i), 64'(ov[i]), 64'd0);
            chk("midrst_sout_valid", wof(i), 64'(sv[i]), 64'd0);
        end
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            nv += int'(vl[0]) + int'(vl[1]) + int'(vl[2]);
        end
        chk("midrst_no_valid", 0, 64'(nv), 64'd0);
        do_op(2'b01, 64'h3, 1'b0, 1'b1, 16'hFFFD, 1'b0);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst_n = 1'b0; st = 3'b111; mode = 2'b01; din = 64'h5;
        @(negedge clk);
        rst_n = 1'b1; st = '0;
        for (int i = 0; i < 3; i++)
            chk("rst_prio_ready", wof(i), 64'(rd[i]), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_prio_idle", wof(i), 64'(rd[i]), 64'd1);
            chk("rst_prio_nosv", wof(i), 64'(sv[i]), 64'd0);
        end

        // Random operands in every mode, with random interference.
        for (int r = 0; r < 40; r++)
            do_op(2'($urandom_range(0, 3)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_twos_complement.md
SERIAL_TWOS_COMPLEMENT -- requirements
Module: serial_twos_complement

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation; sampled only while ready=1.
REQ-005 SHALL have port mode, input, 2 bits: 00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass).
REQ-006 SHALL have port din, input, WIDTH bits: two's-complement operand.
REQ-007 SHALL have port ready, output, 1 bit: high only in state IDLE.
REQ-008 SHALL have port sout, output, 1 bit: bit-serial result, LSB first.
REQ-009 SHALL have port sout_valid, output, 1 bit: sout carries a result bit this cycle.
REQ-010 SHALL have port dout, output, WIDTH bits: parallel result.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse marking dout/ovf complete.
REQ-012 SHALL have port ovf, output, 1 bit: negation overflow flag.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE; transitions: IDLE->SHIFT on start=1; SHIFT->DONE after WIDTH bit cycles; DONE->IDLE unconditionally.
REQ-014 SHALL, on the accepting edge (IDLE, start=1), capture din and mode into internal registers, clear bit counter, seen_one flag, dout and ovf.
REQ-015 SHALL decide the negate enable at capture: 1 for mode 01; din[WIDTH-1] for mode 10; 0 for modes 00 and 11.
REQ-016 SHALL process one bit per SHIFT cycle, LSB first: out_bit = negate & seen_one ? ~bit : bit; then seen_one |= bit.
REQ-017 SHALL drive bit i on sout with sout_valid=1 in the cycle after the (i+1)th SHIFT edge, i = 0..WIDTH-1; sout_valid=0 otherwise.
REQ-018 SHALL shift each out_bit into dout MSB-side so that dout holds the full result when valid rises.
REQ-019 SHALL assert valid for exactly one cycle (state DONE), WIDTH+1 cycles after the accepting edge.
REQ-020 SHALL set ovf=1 iff negate=1 and the operand equals the most negative value (MSB 1, all lower bits 0); the result then equals the operand.
REQ-021 SHALL hold dout and ovf stable from valid until the next accepting edge.
REQ-022 SHALL ignore start while in SHIFT or DONE; the operation in progress is not disturbed; throughput is one operation per WIDTH+2 cycles.
REQ-023 SHALL ignore changes on din and mode after the accepting edge.
REQ-024 SHALL produce a result numerically equal to (~din + 1) mod 2^WIDTH when negating, and to din otherwise.

Reset
REQ-025 SHALL, on any rising edge with rst_n=0, enter IDLE and set dout=0, ovf=0, valid=0, sout=0, sout_valid=0, counter=0, seen_one=0; ready=1 in the following cycle.
REQ-026 SHALL abandon an operation when reset occurs in SHIFT or DONE, with no valid pulse for that operation.
REQ-027 SHALL give reset priority over start on the same edge.

Verification
REQ-028 WIDTH=16, mode=01, din=0x0001 -> sout sequence 1 then fifteen 1s; dout=0xFFFF, ovf=0, valid 17 cycles after the accepting edge.
REQ-029 WIDTH=16, mode=01, din=0x8000 -> dout=0x8000, ovf=1; mode=01, din=0x0000 -> dout=0x0000, ovf=0.
REQ-030 WIDTH=16, mode=10, din=0xFFFB -> dout=0x0005; mode=10, din=0x0005 -> dout=0x0005; mode=11, din=0x1234 -> dout=0x1234.
REQ-031 Start pulsed during SHIFT with different din -> first result unchanged, exactly one valid pulse, ready returns 1 after DONE.
REQ-032 rst_n=0 for one cycle mid-SHIFT -> no valid pulse, outputs zero, ready=1; next operation (mode=01, din=0x0003) -> dout=0xFFFD.
REQ-033 WIDTH=4 and WIDTH=32 with random din in all modes -> dout and serial stream match (~din+1) or din, per REQ-015.
